load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges single core load/store requests onto a word-wide,
// single-cycle data memory. Sub-word stores are done as read-modify-write.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; req_* captured on accept
// READ  | mem_read high; load lane extracted, or RMW word fetched
// WRITE | mem_write high; full word (SW or merged SB/SH) driven out
// RESP  | resp_valid pulse with resp_err / resp_rdata; back to IDLE

module load_store_unit #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int BASE = 'h1000,
    parameter int SIZE = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW-1:0] LAST_A = AW'(BASE + SIZE - 4);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [2:0]    funct3_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] word_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          f3_legal;
    logic          misaligned;
    logic          in_range;
    logic [AW-1:0] req_word_addr;
    logic          req_err;
    logic [DW-1:0] load_val;
    logic [DW-1:0] lane_byte;
    logic [15:0]   lane_half;
    logic [DW-1:0] merged;

    // Classify the incoming request so errors can bypass memory entirely.
    always_comb begin
        f3_legal      = 1'b0;
        req_word_addr = {req_addr[AW-1:2], 2'b00};
        if (req_write)
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        else
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        in_range   = (req_word_addr >= BASE_A) && (req_word_addr <= LAST_A);
        req_err    = !f3_legal || misaligned || !in_range;
    end

    // Pick the addressed lane of the fetched word and extend it.
    always_comb begin
        lane_byte = mem_rdata >> {addr_q[1:0], 3'b000};
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte[7:0]};
            3'b100:  load_val = {24'd0, lane_byte[7:0]};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Merge store data into the fetched word; SW uses the store data directly.
    always_comb begin
        merged = word_q;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (funct3_q[1:0] == 2'b01) begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0]  = wdata_q[15:0];
        end
        mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : merged;
    end

    // Memory strobes and handshake are pure decodes of the state register.
    always_comb begin
        req_ready   = (state == IDLE);
        mem_read    = (state == READ);
        mem_write   = (state == WRITE);
        resp_valid  = (state == RESP);
        mem_address = (mem_read || mem_write) ? {addr_q[AW-1:2], 2'b00} : '0;
        resp_rdata  = rdata_q;
        resp_err    = err_q;
    end

    // Sequencer: capture on accept, walk the access, clear results after RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                        if (req_err)
                            state <= RESP;
                        else if (req_write && (req_funct3[1:0] == 2'b10))
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (write_q) begin
                        word_q <= mem_rdata;
                        state  <= WRITE;
                    end else begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests compared against a byte-level reference model of the memory.

module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h1000;
    localparam int          SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    load_store_unit #(.AW(32), .DW(32), .BASE('h1000), .SIZE(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic bit in_mem(logic [31:0] a);
        return (a >= BASE) && (a <= BASE + SIZE - 4);
    endfunction

    function automatic logic [7:0] idx(logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return o[7:0];
    endfunction

    assign mem_rdata = in_mem(mem_address) ? mem[idx(mem_address)] : 32'h0BAD0BAD;

    always @(posedge clk)
        if (mem_write && in_mem(mem_address))
            mem[idx(mem_address)] <= mem_wdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle invariants: address parked at 0 when idle, strobes exclusive.
    always @(negedge clk) begin
        if (!rst) begin
            if (!mem_read && !mem_write)
                chk("addr_idle", mem_address, 32'd0);
            chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
        end
    end

    // Reference: outcome of one request from the architectural rules.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output bit err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] wword);
        int size;
        int b;
        bit legal;
        logic [31:0] a;
        logic [31:0] word;
        logic [31:0] v;
        legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        size  = 1 << int'(f3[1:0]);
        a     = addr & ~32'd3;
        err   = !legal || ((addr % 32'(size)) != 0) || !in_mem(a);
        rdata = 32'd0;
        wword = 32'd0;
        nrd   = 0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            word = ref_mem[idx(a)];
            v = word >> (8 * int'(addr[1:0]));
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 < 3'd4 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end else begin
                v = word;
            end
            rdata = v;
            lat   = 2;
            nrd   = 1;
        end else begin
            word = ref_mem[idx(a)];
            for (int i = 0; i < size; i++) begin
                b = int'(addr[1:0]) + i;
                word = (word & ~(32'hFF << (8 * b))) | (((wd >> (8 * i)) & 32'hFF) << (8 * b));
            end
            wword = word;
            ref_mem[idx(a)] = word;
            nwr = 1;
            nrd = (size == 4) ? 0 : 1;
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // Present a request at a negedge and return just after the accepting edge.
    task automatic send(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int waits);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waits = 0;
        while (!req_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready)
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic expect_resp(input bit err, input logic [31:0] rdata, input int lat,
                               input int nrd, input int nwr, input logic [31:0] a,
                               input logic [31:0] wword, input bit hold);
        int rd = 0;
        int wc = 0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write  = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                req_valid  = hold;
            end
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("resp_valid_timing", {31'd0, resp_valid}, {31'd0, c == lat});
            if (mem_read) begin
                rd++;
                chk("rd_addr", mem_address, a);
            end
            if (mem_write) begin
                wc++;
                chk("wr_addr", mem_address, a);
                chk("wr_data", mem_wdata, wword);
            end
            if (c == lat) begin
                chk("resp_err", {31'd0, resp_err}, {31'd0, err});
                chk("resp_rdata", resp_rdata, rdata);
            end
        end
        chk("n_reads", rd, nrd);
        chk("n_writes", wc, nwr);
    endtask

    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold,
                          output bit me, output logic [31:0] mr, output logic [31:0] mw,
                          output int waits);
        int lat, nrd, nwr;
        send(wr, f3, addr, wd, waits);
        model(wr, f3, addr, wd, me, mr, lat, nrd, nwr, mw);
        expect_resp(me, mr, lat, nrd, nwr, addr & ~32'd3, mw, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          me;
        logic [31:0] mr, mw, addr, wd;
        logic [2:0]  f3;
        int          waits, r;
        bit          wr;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h8899AABB;  ref_mem[1] = 32'h8899AABB;
        mem[2] = 32'h11223344;  ref_mem[2] = 32'h11223344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_req(1'b0, 3'b000, 32'h1005, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lb_model", mr, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h1005, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lbu_model", mr, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h1006, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lh_model", mr, 32'hFFFF8899);
        do_req(1'b1, 3'b000, 32'h100A, 32'hDEADBEEF, 1'b0, me, mr, mw, waits);
        chk("sb_merge_model", mw, 32'h11EF3344);
        do_req(1'b1, 3'b010, 32'h1010, 32'hCAFEF00D, 1'b0, me, mr, mw, waits);
        chk("sw_data_model", mw, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h1010, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lw_after_sw", mr, 32'hCAFEF00D);

        do_req(1'b0, 3'b010, 32'h1002, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lw_misaligned_err", {31'd0, me}, 32'd1);
        do_req(1'b0, 3'b001, 32'h1001, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lh_misaligned_err", {31'd0, me}, 32'd1);
        do_req(1'b0, 3'b000, 32'h0FFF, 32'd0, 1'b0, me, mr, mw, waits);
        chk("lb_range_err", {31'd0, me}, 32'd1);
        do_req(1'b0, 3'b011, 32'h1000, 32'd0, 1'b0, me, mr, mw, waits);
        chk("f3_011_err", {31'd0, me}, 32'd1);
        do_req(1'b1, 3'b010, BASE + SIZE - 4, 32'h5A5A1234, 1'b0, me, mr, mw, waits);
        do_req(1'b0, 3'b010, BASE + SIZE, 32'd0, 1'b0, me, mr, mw, waits);
        chk("past_end_err", {31'd0, me}, 32'd1);

        do_req(1'b0, 3'b010, 32'h1020, 32'd0, 1'b1, me, mr, mw, waits);
        do_req(1'b0, 3'b010, 32'h1024, 32'd0, 1'b0, me, mr, mw, waits);
        chk("b2b_gap_waits", waits, 32'd1);

        send(1'b1, 3'b001, 32'h1040, 32'h0000BEEF, waits);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_op_read_cycle", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_resp_err", {31'd0, resp_err}, 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        chk("abort_mem_address", mem_address, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_no_commit", mem[idx(32'h1040)], ref_mem[idx(32'h1040)]);

        for (int n = 0; n < 250; n++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                f3 = 3'($urandom);
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)
                addr = $urandom;
            else if (r == 1)
                addr = BASE - 32'd8 + 32'($urandom_range(0, 15));
            else if (r == 2)
                addr = BASE + SIZE - 32'd8 + 32'($urandom_range(0, 15));
            else
                addr = BASE + 32'($urandom_range(0, SIZE - 1));
            wd = $urandom;
            do_req(wr, f3, addr, wd, 1'($urandom), me, mr, mw, waits);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i])
                chk("final_mem", mem[i], ref_mem[i]);
        chk("final_mem_word0", mem[0], ref_mem[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
